fifo_uart_tx: RTL and testbench

Byte-serial UART transmitter that drains the synchronous FIFO on its read side. It watches the FIFO `empty` flag and issues single-cycle read strobes. It captures the word the FIFO presents one clock after the strobe and shifts it out LSB-first as an 8N1/8E1/8O1/8N2 asynchronous frame. It sits directly downstream of the FIFO and is the last stage before the serial pad.

---
 rtl/fifo_uart_tx.sv | 151 +++++++++++++++
 tb/tb_fifo_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls bytes from a synchronous FIFO read port and
// serialises them LSB-first with optional parity and one or two stop bits.
module fifo_uart_tx #(
   parameter int unsigned DATA_WIDTH   = 8,
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1,
   parameter int unsigned PARITY_EN    = 0,
   parameter int unsigned PARITY_ODD   = 0
) (
   input  logic                  clk,
   input  logic                  rst_a_n,
   input  logic                  tx_en,
   input  logic                  fifo_empty,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic                  fifo_rd_en,
   output logic                  tx,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned BIT_W  = $clog2(DATA_WIDTH) + 1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
   localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_e;

   state_e                state_q, state_d;
   logic [BAUD_W-1:0]     baud_q, baud_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  par_q, par_d;
   logic                  tx_q, tx_d;
   logic                  frame_done_q, frame_done_d;
   logic                  counting;
   logic                  baud_last;

   // Next-state, datapath and registered-output decode
   always_comb begin
      state_d   = state_q;
      baud_d    = '0;
      bit_d     = bit_q;
      shift_d   = shift_q;
      par_d     = par_q;
      counting  = (state_q inside {S_START, S_DATA, S_PARITY, S_STOP});
      baud_last = counting && (baud_q == BAUD_LAST);

      // Baud counter restarts at every bit boundary, which covers every state entry
      if (counting && !baud_last) begin
         baud_d = baud_q + BAUD_W'(1);
      end

      unique case (state_q)
         S_IDLE: begin
            if (tx_en && !fifo_empty) begin
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            state_d = S_LOAD;
         end
         S_LOAD: begin
            shift_d = fifo_data;
            par_d   = (^fifo_data) ^ 1'(PARITY_ODD);
            bit_d   = '0;
            state_d = S_START;
         end
         S_START: begin
            if (baud_last) begin
               bit_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_last) begin
               shift_d = shift_q >> 1;
               if (bit_q == DATA_LAST) begin
                  bit_d   = '0;
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         S_PARITY: begin
            if (baud_last) begin
               state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (baud_last) begin
               if (bit_q == STOP_LAST) begin
                  bit_d   = '0;
                  state_d = S_IDLE;
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase

      frame_done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);
   end

   always_ff @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n) begin
         state_q      <= S_IDLE;
         baud_q       <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         par_q        <= 1'b0;
         tx_q         <= 1'b1;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         baud_q       <= baud_d;
         bit_q        <= bit_d;
         shift_q      <= shift_d;
         par_q        <= par_d;
         tx_q         <= tx_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Read strobe and busy are pure decodes of the state flops
   assign fifo_rd_en = (state_q == S_FETCH);
   assign busy       = (state_q != S_IDLE);
   assign tx         = tx_q;
   assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: three instances (8N1 at 4 clk/bit, 8E1 and 8O1 at 3 clk/bit)
// checked every cycle against a frame-level model, plus literal frame checks.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

   localparam logic [3:0] IDLE_O = 4'b1000;

   logic       clk     = 1'b0;
   logic       rst_a_n = 1'b0;
   logic       tx_en   = 1'b1;
   logic       fe0     = 1'b1;
   logic       fe1     = 1'b1;
   logic [7:0] fd0     = 8'h00;
   logic [7:0] fd1     = 8'h00;

   logic rd_a, tx_a, busy_a, done_a;
   logic rd_b, tx_b, busy_b, done_b;
   logic rd_c, tx_c, busy_c, done_c;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] fq    [2][$];
   logic [3:0] exp_q [3][$];
   logic [3:0] cur   [3] = '{IDLE_O, IDLE_O, IDLE_O};

   int          cyc = 0;
   int          inf      [3] = '{0, 0, 0};
   int          cnt      [3] = '{0, 0, 0};
   int          flen     [3] = '{0, 0, 0};
   int          nfr      [3] = '{0, 0, 0};
   int          rdcnt    [3] = '{0, 0, 0};
   int          low_run  [3] = '{0, 0, 0};
   int          last_low [3] = '{0, 0, 0};
   int          last_rd  [3] = '{0, 0, 0};
   int          rd_gap   [3] = '{0, 0, 0};
   logic [15:0] bits     [3] = '{16'h0, 16'h0, 16'h0};
   logic [15:0] fbits    [3] = '{16'h0, 16'h0, 16'h0};
   logic [3:0]  mo;
   int          pos;
   int          cpb_m;

   always #5 clk = ~clk;

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dut_a (
      .clk(clk), .rst_a_n(rst_a_n), .tx_en(tx_en), .fifo_empty(fe0), .fifo_data(fd0),
      .fifo_rd_en(rd_a), .tx(tx_a), .busy(busy_a), .frame_done(done_a));

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(3), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) dut_b (
      .clk(clk), .rst_a_n(rst_a_n), .tx_en(tx_en), .fifo_empty(fe1), .fifo_data(fd1),
      .fifo_rd_en(rd_b), .tx(tx_b), .busy(busy_b), .frame_done(done_b));

   fifo_uart_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(3), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) dut_c (
      .clk(clk), .rst_a_n(rst_a_n), .tx_en(tx_en), .fifo_empty(fe1), .fifo_data(fd1),
      .fifo_rd_en(rd_c), .tx(tx_c), .busy(busy_c), .frame_done(done_c));

   function automatic int cpb_of(input int d);
      return (d == 0) ? 4 : 3;
   endfunction

   // {tx, rd_en, busy, frame_done}
   function automatic logic [3:0] out_of(input int d);
      case (d)
         0:       return {tx_a, rd_a, busy_a, done_a};
         1:       return {tx_b, rd_b, busy_b, done_b};
         default: return {tx_c, rd_c, busy_c, done_c};
      endcase
   endfunction

   // Expected outputs for one whole transaction: fetch, load, line bits, one idle cycle
   function automatic void plan(input int ch, input logic [7:0] b);
      int   cpb;
      logic lv[$];
      cpb = cpb_of(ch);
      lv.push_back(1'b0);
      for (int i = 0; i < 8; i++) lv.push_back(b[i]);
      if (ch != 0) lv.push_back((^b) ^ (ch == 2));
      lv.push_back(1'b1);
      exp_q[ch].push_back(4'b1110);
      exp_q[ch].push_back(4'b1010);
      for (int k = 0; k < lv.size(); k++) begin
         for (int c = 0; c < cpb; c++) begin
            exp_q[ch].push_back({lv[k], 1'b0, 1'b1, (k == lv.size() - 1) && (c == cpb - 1)});
         end
      end
      exp_q[ch].push_back(IDLE_O);
   endfunction

   // Model: decides at each edge what the next cycle must look like
   always @(posedge clk) begin
      for (int ch = 0; ch < 3; ch++) begin
         if (!rst_a_n) begin
            exp_q[ch].delete();
            cur[ch] = IDLE_O;
         end else begin
            if (exp_q[ch].size() == 0 && tx_en && !((ch == 0) ? fe0 : fe1)) begin
               plan(ch, (ch == 0) ? fq[0][0] : fq[1][0]);
            end
            if (exp_q[ch].size() > 0) cur[ch] = exp_q[ch].pop_front();
            else cur[ch] = IDLE_O;
         end
      end
   end

   // Compare, frame monitor and FIFO read side, all on the falling edge
   always @(negedge clk) begin
      cyc++;
      for (int d = 0; d < 3; d++) begin
         mo = out_of(d);
         n_cmp++;
         if (mo !== cur[d]) begin
            n_bad++;
            $display("FAIL outputs dut%0d cyc=%0d actual tx,rd,busy,done=%b required=%b", d, cyc, mo, cur[d]);
         end
         if (!rst_a_n) begin
            inf[d]     = 0;
            low_run[d] = 0;
         end else begin
            if (!mo[1]) low_run[d]++;
            else if (low_run[d] > 0) begin
               last_low[d] = low_run[d];
               low_run[d]  = 0;
            end
            if (mo[2]) begin
               rd_gap[d]  = cyc - last_rd[d];
               last_rd[d] = cyc;
               rdcnt[d]++;
            end
            if (inf[d] == 0 && mo[3] == 1'b0) begin
               inf[d]  = 1;
               cnt[d]  = 0;
               bits[d] = 16'h0;
            end
            if (inf[d] != 0) begin
               cpb_m = cpb_of(d);
               pos   = cnt[d];
               if (pos % cpb_m == cpb_m / 2) bits[d][pos / cpb_m] = mo[3];
               cnt[d]++;
               if (mo[0]) begin
                  flen[d]  = cnt[d];
                  fbits[d] = bits[d];
                  inf[d]   = 0;
                  nfr[d]++;
               end
            end
         end
      end
      if (rst_a_n && rd_a) begin
         if (fq[0].size() > 0) fd0 = fq[0].pop_front();
         else begin
            n_cmp++; n_bad++;
            $display("FAIL underflow fifo0 cyc=%0d actual read_on_empty=1 required=0", cyc);
         end
      end
      if (rst_a_n && rd_b) begin
         if (fq[1].size() > 0) fd1 = fq[1].pop_front();
         else begin
            n_cmp++; n_bad++;
            $display("FAIL underflow fifo1 cyc=%0d actual read_on_empty=1 required=0", cyc);
         end
      end
      fe0 = (fq[0].size() == 0);
      fe1 = (fq[1].size() == 0);
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_bad++;
         $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", nm, act, act, req, req);
      end
   endtask

   task automatic wait_frames(input int d, input int n, input int budget);
      int start;
      int k;
      start = nfr[d];
      k = 0;
      while (nfr[d] < start + n && k < budget) begin
         tick();
         k++;
      end
      if (nfr[d] < start + n) begin
         n_cmp++; n_bad++;
         $display("FAIL frame_timeout dut%0d actual frames=%0d required=%0d", d, nfr[d] - start, n);
      end
   endtask

   task automatic wait_rd(input int d, input int budget);
      int start;
      int k;
      start = rdcnt[d];
      k = 0;
      while (rdcnt[d] == start && k < budget) begin
         tick();
         k++;
      end
      if (rdcnt[d] == start) begin
         n_cmp++; n_bad++;
         $display("FAIL rd_timeout dut%0d actual strobes=0 required=1", d);
      end
   endtask

   initial begin
      int f0;
      int r0;

      // Reset held with data available and transmit enabled
      fq[0].push_back(8'hA5);
      fq[1].push_back(8'hA5);
      repeat (5) tick();
      chk("reset_tx", int'(tx_a), 1);
      chk("reset_rd", int'(rd_a), 0);
      chk("reset_busy", int'(busy_a), 0);
      chk("reset_done", int'(done_a), 0);
      rst_a_n = 1'b1;
      tick();
      chk("first_rd_a", int'(rd_a), 1);
      chk("first_rd_b", int'(rd_b), 1);

      // Single 0xA5 frame on all three instances
      wait_frames(0, 1, 100);
      chk("a5_bits", int'(fbits[0][9:0]), 'h34A);
      chk("a5_len", flen[0], 40);
      chk("a5_rd_count", rdcnt[0], 1);
      chk("a5_even_parity", int'(fbits[1][9]), 0);
      chk("a5_odd_parity", int'(fbits[2][9]), 1);
      chk("parity_len", flen[1], 33);

      // Back-to-back 0x00 then 0xFF; 0x07 on the parity pair
      fq[0].push_back(8'h00);
      fq[0].push_back(8'hFF);
      fq[1].push_back(8'h07);
      wait_frames(0, 2, 250);
      chk("b2b_rd_gap", rd_gap[0], 43);
      chk("b2b_busy_low", last_low[0], 1);
      chk("ff_bits", int'(fbits[0][9:0]), 'h3FE);
      chk("ff_len", flen[0], 40);
      chk("p07_even_parity", int'(fbits[1][9]), 1);

      // Empty FIFO: no strobes, line idle
      r0 = rdcnt[0];
      repeat (30) tick();
      chk("empty_no_rd", rdcnt[0] - r0, 0);
      chk("empty_tx", int'(tx_a), 1);

      // tx_en dropped during DATA: frame completes, nothing further
      fq[0].push_back(8'h11);
      fq[0].push_back(8'h22);
      wait_rd(0, 20);
      repeat (9) tick();
      tx_en = 1'b0;
      f0 = nfr[0];
      r0 = rdcnt[0];
      repeat (80) tick();
      chk("drop_frames", nfr[0] - f0, 1);
      chk("drop_no_rd", rdcnt[0] - r0, 0);
      chk("drop_bits", int'(fbits[0][9:0]), 'h222);

      // Reset during data bit 3, then a fresh frame
      tx_en = 1'b1;
      wait_rd(0, 20);
      repeat (19) tick();
      #1 rst_a_n = 1'b0;
      #1;
      chk("midrst_tx", int'(tx_a), 1);
      chk("midrst_busy", int'(busy_a), 0);
      fq[0].push_back(8'h3C);
      repeat (3) tick();
      r0 = rdcnt[0];
      rst_a_n = 1'b1;
      wait_frames(0, 1, 100);
      chk("postrst_rd", rdcnt[0] - r0, 1);
      chk("postrst_bits", int'(fbits[0][9:0]), 'h278);

      // Random traffic and enable toggling, then drain
      repeat (400) begin
         tick();
         if ($urandom_range(0, 7) == 0 && fq[0].size() < 3) fq[0].push_back(8'($urandom));
         if ($urandom_range(0, 7) == 0 && fq[1].size() < 3) fq[1].push_back(8'($urandom));
         tx_en = ($urandom_range(0, 9) != 0);
      end
      tx_en = 1'b1;
      repeat (250) tick();
      chk("drain_empty", fq[0].size() + fq[1].size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
